rv32_alu_mc_fsm: RTL

RV32_ALU_MC_FSM -- requirements
Module: rv32_alu_mc_fsm

---
 rtl/rv32_alu_pkg.sv | 44 ++++
 rtl/rv32_alu_mc_fsm_if.sv | 27 ++
 rtl/rv32_alu_slice_adder.sv | 12 +
 rtl/rv32_alu_mc_fsm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_alu_pkg.sv
// Shared opcode/state types and helpers for the multi-cycle RV32 ALU.
package rv32_alu_pkg;

    localparam int ALU_SEL_W = 4;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARITH,
        ST_SHIFT,
        ST_DONE
    } alu_state_e;

    // Unassigned opcode values fall back to ADD.
    function automatic alu_op_e decode_op(input logic [ALU_SEL_W-1:0] sel);
        if (sel <= 4'd9) return alu_op_e'(sel);
        return ALU_ADD;
    endfunction

    function automatic logic is_arith(input alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

    function automatic logic uses_sub(input alu_op_e op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/rv32_alu_mc_fsm_if.sv
// Request/response bundle between an ALU client (master) and the ALU (slave).
interface rv32_alu_mc_fsm_if #(parameter int WIDTH = 32);
    import rv32_alu_pkg::*;

    logic                 i_en_alu;
    logic [WIDTH-1:0]     i_operand_one;
    logic [WIDTH-1:0]     i_operand_two;
    logic [ALU_SEL_W-1:0] i_alu_sel;
    logic                 i_ack;
    logic                 i_flush;
    logic                 o_ready;
    logic                 o_data_valid;
    logic [WIDTH-1:0]     o_result;
    logic                 o_carry_out;
    logic                 o_overflow;
    logic                 o_zero;

    modport master (
        output i_en_alu, i_operand_one, i_operand_two, i_alu_sel, i_ack, i_flush,
        input  o_ready, o_data_valid, o_result, o_carry_out, o_overflow, o_zero
    );

    modport slave (
        input  i_en_alu, i_operand_one, i_operand_two, i_alu_sel, i_ack, i_flush,
        output o_ready, o_data_valid, o_result, o_carry_out, o_overflow, o_zero
    );
endinterface

// File: rtl/rv32_alu_slice_adder.sv
// SLICE-bit ripple adder with carry in/out, reused once per ARITH cycle.
module rv32_alu_slice_adder #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
endmodule

// File: rtl/rv32_alu_mc_fsm.sv
// Multi-cycle RV32 ALU: sliced adder for arithmetic, bit-serial shifter,
// result held in DONE until ack or flush.
//
// state    | meaning
// ST_IDLE  | ready, waiting for a request
// ST_ARITH | one adder slice per cycle, LSB first
// ST_SHIFT | one shift bit per cycle; single pass for logic ops / zero shifts
// ST_DONE  | result and flags valid, waiting for ack
module rv32_alu_mc_fsm
    import rv32_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    rv32_alu_mc_fsm_if.slave alu
);
    localparam int N_SLICE = WIDTH / SLICE;
    localparam int CNT_W   = $clog2(WIDTH);

    if (WIDTH % SLICE != 0) begin : g_slice_check
        $error("rv32_alu_mc_fsm: WIDTH must be a multiple of SLICE");
    end

    alu_state_e       state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cin_q, cin_d, a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic             shift_en_q, shift_en_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, valid_q, valid_d;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] sum_ext, sum_full, shifted;
    logic [CNT_W-1:0] shamt;
    logic             ovf_raw, slt_bit;

    rv32_alu_slice_adder #(.SLICE(SLICE)) u_slice_adder (
        .a    (a_q[SLICE-1:0]),
        .b    (b_q[SLICE-1:0]),
        .cin  (cin_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Slices fill the accumulator from the top so the LSB slice lands at bit 0 last.
    assign sum_ext  = WIDTH'(slice_sum) << (WIDTH - SLICE);
    assign sum_full = (acc_q >> SLICE) | sum_ext;
    assign ovf_raw  = (a_sign_q == b_sign_q) && (sum_full[WIDTH-1] != a_sign_q);
    assign slt_bit  = sum_full[WIDTH-1] ^ ovf_raw;
    assign shamt    = alu.i_operand_two[CNT_W-1:0];

    always_comb begin
        shifted = a_q;
        if (shift_en_q) begin
            case (op_q)
                ALU_SLL: shifted = a_q << 1;
                ALU_SRL: shifted = a_q >> 1;
                ALU_SRA: shifted = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                default: shifted = a_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        cin_d      = cin_q;
        a_sign_d   = a_sign_q;
        b_sign_d   = b_sign_q;
        shift_en_d = shift_en_q;
        result_d   = result_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (alu.i_en_alu) begin
                    op_d       = decode_op(alu.i_alu_sel);
                    a_d        = alu.i_operand_one;
                    b_d        = uses_sub(op_d) ? ~alu.i_operand_two : alu.i_operand_two;
                    cin_d      = uses_sub(op_d);
                    a_sign_d   = alu.i_operand_one[WIDTH-1];
                    b_sign_d   = b_d[WIDTH-1];
                    acc_d      = '0;
                    shift_en_d = is_shift(op_d) && (shamt != '0);
                    if (is_arith(op_d)) begin
                        state_d = ST_ARITH;
                        cnt_d   = CNT_W'(N_SLICE - 1);
                    end else begin
                        // Logic ops and zero shifts take a single non-shifting pass.
                        state_d = ST_SHIFT;
                        cnt_d   = shift_en_d ? shamt - CNT_W'(1) : '0;
                    end
                end
            end
            ST_ARITH: begin
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                cin_d = slice_cout;
                acc_d = sum_full;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    case (op_q)
                        ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_bit};
                        ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, ~slice_cout};
                        default: begin
                            result_d = sum_full;
                            carry_d  = slice_cout;
                            ovf_d    = ovf_raw;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                a_d   = shifted;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    case (op_q)
                        ALU_AND: result_d = a_q & b_q;
                        ALU_OR:  result_d = a_q | b_q;
                        ALU_XOR: result_d = a_q ^ b_q;
                        default: result_d = shifted;
                    endcase
                end
            end
            ST_DONE: begin
                if (alu.i_ack) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (alu.i_flush) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            cin_q      <= 1'b0;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            shift_en_q <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            cin_q      <= cin_d;
            a_sign_q   <= a_sign_d;
            b_sign_q   <= b_sign_d;
            shift_en_q <= shift_en_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign alu.o_ready      = (state_q == ST_IDLE);
    assign alu.o_data_valid = valid_q;
    assign alu.o_result     = result_q;
    assign alu.o_carry_out  = carry_q;
    assign alu.o_overflow   = ovf_q;
    assign alu.o_zero       = valid_q && (result_q == '0);
endmodule
